// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder_tree front end (line_feeder).
package adder_pkg;

  localparam int DEFAULT_PIXEL_SIZE = 8;
  localparam int DEFAULT_LINE_SIZE  = 16;

  typedef enum logic [1:0] {FILL, WAIT, OUT} feeder_state_t;

  // Width of a full line sum: one product width plus enough carry bits for LINE_SIZE terms.
  function automatic int sum_w(input int line_size, input int pixel_size);
    return $clog2(line_size) + 2 * pixel_size;
  endfunction

endpackage

// File: rtl/line_feeder.sv
// Packs a serial product stream into one adder_tree line, waits out the tree latency, then hands the sum downstream.
// Optional LINE_FEEDER_ZERO_PAD_EN: pix_last closes a line early and zero-fills the remaining slots.
module line_feeder
  import adder_pkg::*;
#(
  parameter int PIXEL_SIZE   = DEFAULT_PIXEL_SIZE,
  parameter int LINE_SIZE    = DEFAULT_LINE_SIZE,
  parameter int TREE_LATENCY = $clog2(LINE_SIZE),
  localparam int SUM_W       = sum_w(LINE_SIZE, PIXEL_SIZE),
  localparam int PW          = 2 * PIXEL_SIZE
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PW-1:0]             pix_in,
  input  logic                      pix_valid,
  input  logic                      pix_last,
  output logic                      pix_ready,
  output logic [PW*LINE_SIZE-1:0]   line_out,
  input  logic [SUM_W-1:0]          line_sum_in,
  output logic [SUM_W-1:0]          sum_out,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic [15:0]               line_cnt
);

  localparam int IDX_W = $clog2(LINE_SIZE);
  localparam int CNT_W = $clog2(TREE_LATENCY + 2);

  feeder_state_t            state, next_state;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         wait_cnt;
  logic [PW*LINE_SIZE-1:0]  line_next;
  logic                     xfer, end_line, pad_line, wait_done, sum_hs;

  assign xfer      = (state == FILL) && pix_valid;
  assign wait_done = (state == WAIT) && (wait_cnt == '0);
  assign sum_hs    = (state == OUT) && sum_valid && sum_ready;

`ifdef LINE_FEEDER_ZERO_PAD_EN
  assign pad_line = xfer && pix_last;
`else
  logic unused_pix_last;
  assign unused_pix_last = pix_last;
  assign pad_line        = 1'b0;
`endif

  assign end_line = (xfer && (idx == IDX_W'(LINE_SIZE - 1))) || pad_line;

  always_comb begin
    next_state = state;
    pix_ready  = 1'b0;
    case (state)
      FILL: begin
        pix_ready = 1'b1;
        if (end_line) next_state = WAIT;
      end
      WAIT: if (wait_done) next_state = OUT;
      OUT:  if (sum_hs) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Slot write; on an early end every slot above the written one is cleared in the same edge.
  always_comb begin
    line_next = line_out;
    if (xfer) begin
      for (int s = 0; s < LINE_SIZE; s++) begin
        if (s == int'(idx))
          line_next[s*PW +: PW] = pix_in;
        else if (pad_line && (s > int'(idx)))
          line_next[s*PW +: PW] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FILL;
      idx       <= '0;
      wait_cnt  <= '0;
      line_out  <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      line_cnt  <= '0;
    end else begin
      state    <= next_state;
      line_out <= line_next;
      if (xfer)
        idx <= end_line ? '0 : idx + 1'b1;
      if (end_line)
        wait_cnt <= CNT_W'(TREE_LATENCY);
      else if ((state == WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;
      if (wait_done) begin
        sum_out   <= line_sum_in;
        sum_valid <= 1'b1;
      end
      if (sum_hs) begin
        sum_valid <= 1'b0;
        line_cnt  <= line_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Self-checking bench for line_feeder with a behavioural 4-stage adder tree attached.
module tb_line_feeder;

  localparam int PS = 8;
  localparam int LS = 16;
  localparam int TL = 4;
  localparam int SW = 20;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PW-1:0]     pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_last = 1'b0;
  logic              pix_ready;
  logic [PW*LS-1:0]  line_out;
  logic [SW-1:0]     line_sum_in;
  logic [SW-1:0]     sum_out;
  logic              sum_valid;
  logic              sum_ready = 1'b1;
  logic [15:0]       line_cnt;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  line_feeder #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .TREE_LATENCY(TL)) dut (
    .CLK(clk), .RST(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_ready(pix_ready), .line_out(line_out), .line_sum_in(line_sum_in),
    .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready), .line_cnt(line_cnt)
  );

  // Adder tree stand-in: full sum of the line, delayed by TL registers.
  logic [SW-1:0] tree_comb;
  logic [SW-1:0] pipe [TL];
  always_comb begin
    tree_comb = '0;
    for (int k = 0; k < LS; k++) tree_comb = tree_comb + SW'(line_out[k*PW +: PW]);
  end
  always_ff @(posedge clk) begin
    pipe[0] <= tree_comb;
    for (int k = 1; k < TL; k++) pipe[k] <= pipe[k-1];
  end
  assign line_sum_in = pipe[TL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] ref_sum(input logic [PW-1:0] px [LS], input int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc += int'(px[i]);
    return SW'(acc);
  endfunction

  // Offer n pixels, optionally with idle gaps; returns at the negedge after the final transfer.
  task automatic feed(input logic [PW-1:0] px [LS], input int n, input bit last_on_final, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) begin pix_valid = 1'b0; @(negedge clk); end
      pix_valid = 1'b1;
      pix_in    = px[i];
      pix_last  = last_on_final && (i == n - 1);
      begin
        int w = 0;
        while (!pix_ready && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) chk("feed_ready_timeout", pix_ready, 1);
      end
      @(posedge clk);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Wait for the sum, check latency/value, optionally stall with a pixel held, then handshake.
  task automatic finish_line(input logic [SW-1:0] exp_sum, input int stall, input bit hold,
                             input logic [PW-1:0] hold_val, input logic [PW-1:0] slot0);
    int n = 0;
    bit rdy_ok = 1'b1;
    bit stable = 1'b1;
    logic [SW-1:0] held;
    if (hold) begin pix_valid = 1'b1; pix_in = hold_val; end
    while (!sum_valid && n < 50) begin
      if (pix_ready) rdy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("sum_latency", n, TL + 1);
    chk("pix_ready_wait", rdy_ok, 1);
    chk("sum_value", sum_out, exp_sum);
    held = sum_out;
    if (stall > 0) begin
      sum_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (sum_out !== held || !sum_valid || pix_ready) stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      sum_ready = 1'b1;
    end
    @(posedge clk);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    chk("sum_valid_drop", sum_valid, 0);
    chk("line_cnt", line_cnt, exp_cnt);
    if (hold) chk("no_accept_in_out", line_out[PW-1:0], slot0);
  endtask

  typedef struct {
    logic [PW-1:0] base;
    logic [PW-1:0] step;
    int            gap;
    int            stall;
    logic [SW-1:0] exp_sum;
  } vec_t;

  vec_t          vt [6];
  logic [PW-1:0] px  [LS];
  logic [PW-1:0] px2 [LS];

  initial begin
    vt[0] = '{16'h0001, 16'h0000, 0, 0, 20'd16};
    vt[1] = '{16'hFFFF, 16'h0000, 0, 0, 20'hFFFF0};
    vt[2] = '{16'h0001, 16'h0001, 2, 3, 20'd136};
    vt[3] = '{16'h0064, 16'h0064, 1, 0, 20'd13600};
    vt[4] = '{16'h8000, 16'h0000, 0, 2, 20'h80000};
    vt[5] = '{16'hFFF0, 16'h0001, 1, 1, 20'hFFF78};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_line_out", (line_out == '0), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1);

    // Table-driven lines
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < LS; i++) px[i] = vt[v].base + vt[v].step * PW'(i);
      feed(px, LS, 1'b0, vt[v].gap);
      finish_line(vt[v].exp_sum, vt[v].stall, 1'b0, '0, '0);
    end

    // Random line, 10-cycle stall with the next line's first pixel held
    for (int i = 0; i < LS; i++) px[i] = PW'($urandom);
    for (int i = 0; i < LS; i++) px2[i] = PW'($urandom);
    px2[0] = px[0] ^ 16'h0001;
    feed(px, LS, 1'b0, 0);
    finish_line(ref_sum(px, LS), 10, 1'b1, px2[0], px[0]);
    feed(px2, LS, 1'b0, 0);
    finish_line(ref_sum(px2, LS), 0, 1'b0, '0, '0);

    // Reset pulse after 7 transfers
    for (int i = 0; i < LS; i++) px[i] = PW'($urandom);
    feed(px, 7, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_line_out", (line_out == '0), 1);
    chk("mid_rst_sum_out", sum_out, 0);
    chk("mid_rst_line_cnt", line_cnt, 0);
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    chk("mid_rst_pix_ready", pix_ready, 1);
    for (int i = 0; i < LS; i++) px[i] = PW'(i + 1);
    feed(px, LS, 1'b0, 0);
    finish_line(20'd136, 0, 1'b0, '0, '0);

    // Early end of line with pix_last on the 4th transfer
    px[0] = 16'd100; px[1] = 16'd200; px[2] = 16'd300; px[3] = 16'd400;
    feed(px, 4, 1'b1, 0);
`ifdef LINE_FEEDER_ZERO_PAD_EN
    chk("pad_upper_zero", (line_out[PW*LS-1:4*PW] == '0), 1);
    finish_line(20'd1000, 0, 1'b0, '0, '0);
`else
    begin
      bit quiet = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (sum_valid || !pix_ready) quiet = 1'b0;
      end
      chk("no_pad_waits", quiet, 1);
    end
    for (int i = 0; i < LS; i++) px2[i] = '0;
    feed(px2, 12, 1'b1, 0);
    finish_line(20'd1000, 0, 1'b0, '0, '0);
`endif

    // 300 random lines after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    for (int l = 0; l < 300; l++) begin
      for (int i = 0; i < LS; i++) px[i] = PW'($urandom);
      feed(px, LS, 1'b0, (l % 3 == 0) ? 1 : 0);
      finish_line(ref_sum(px, LS), int'($urandom_range(2, 0)), 1'b0, '0, '0);
    end
    chk("line_cnt_300", line_cnt, 16'd300);

    // Counter wrap
    force dut.line_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.line_cnt;
    exp_cnt = 16'hFFFF;
    for (int i = 0; i < LS; i++) px[i] = PW'($urandom);
    feed(px, LS, 1'b0, 0);
    finish_line(ref_sum(px, LS), 0, 1'b0, '0, '0);
    chk("line_cnt_wrap", line_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
